mode_switch_sequencer: RTL

//  Sequences glitch-free resolution/source/output changes requested over UART.

---
 rtl/mode_switch_sequencer_if.sv | 26 ++
 rtl/mode_switch_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mode_switch_sequencer_if.sv
// Request/selection bundle between the UART front end, the sequencer and the video pipeline.
interface mode_switch_sequencer_if;
  logic       req_valid;
  logic [1:0] req_res;
  logic [1:0] req_img;
  logic       req_out;
  logic [3:0] clk_lock_vec;
  logic       vsync_tp;
  logic [1:0] Res_Select;
  logic [1:0] Img_Select;
  logic       Out_Select;
  logic       blank;
  logic       tmds_rst;
  logic       busy;
  logic       lock_err;

  modport master (
    output req_valid, req_res, req_img, req_out, clk_lock_vec, vsync_tp,
    input  Res_Select, Img_Select, Out_Select, blank, tmds_rst, busy, lock_err
  );

  modport slave (
    input  req_valid, req_res, req_img, req_out, clk_lock_vec, vsync_tp,
    output Res_Select, Img_Select, Out_Select, blank, tmds_rst, busy, lock_err
  );
endinterface

// File: rtl/mode_switch_sequencer.sv
// Glitch-free mode switching: waits for vblank, blanks, commits the new selection,
// holds TMDS in reset until the selected clock is locked and stable, then unblanks.
module mode_switch_sequencer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned VS_TIMEOUT    = 2000000,
  parameter int unsigned BLANK_CYCLES  = 16,
  parameter int unsigned LOCK_STABLE   = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 10000000,
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter logic [1:0]  RESET_RES     = 2'b00
) (
  input logic                    CLK,
  input logic                    RST,
  mode_switch_sequencer_if.slave bus
);

  localparam int unsigned M1   = (VS_TIMEOUT > BLANK_CYCLES) ? VS_TIMEOUT : BLANK_CYCLES;
  localparam int unsigned M2   = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned CMAX = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned SW   = $clog2(LOCK_STABLE + 1);

  localparam logic [CW-1:0] VS_LAST     = CW'(VS_TIMEOUT - 1);
  localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST   = SW'(LOCK_STABLE - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_VS, BLANK, SWITCH, WAIT_LOCK, SETTLE, FAULT
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] vs_sync;
  logic [3:0]             lock_sync [SYNC_STAGES];
  logic                   vs_d;
  logic                   vs_edge;
  logic [3:0]             lock_now;
  logic                   lock_sel;

  logic [CW-1:0] cnt;
  logic [SW-1:0] stab;

  logic [1:0] res_q, img_q;
  logic       out_q, blank_q, tmds_q, busy_q, err_q;

  logic [4:0] req_now, committed, req_lat, lat_val, pend_val, pend_val_eff;
  logic       pend, pend_eff, lat_load, pend_set, pend_clr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vs_sync <= '0;
      vs_d    <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) lock_sync[i] <= '0;
    end else begin
      vs_sync[0]   <= bus.vsync_tp;
      lock_sync[0] <= bus.clk_lock_vec;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        vs_sync[i]   <= vs_sync[i-1];
        lock_sync[i] <= lock_sync[i-1];
      end
      vs_d <= vs_sync[SYNC_STAGES-1];
    end
  end

  assign vs_edge   = vs_sync[SYNC_STAGES-1] & ~vs_d;
  assign lock_now  = lock_sync[SYNC_STAGES-1];
  assign lock_sel  = lock_now[res_q];
  assign req_now   = {bus.req_res, bus.req_img, bus.req_out};
  assign committed = {res_q, img_q, out_q};

  // A request arriving in the same cycle SETTLE completes overrides any older pending one.
  assign pend_eff     = pend | bus.req_valid;
  assign pend_val_eff = bus.req_valid ? req_now : pend_val;

  always_comb begin
    state_nxt = state;
    lat_load  = 1'b0;
    lat_val   = req_now;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (!lock_sel) begin
          state_nxt = WAIT_LOCK;
          pend_set  = bus.req_valid;
        end else if (bus.req_valid && req_now != committed) begin
          lat_load  = 1'b1;
          state_nxt = WAIT_VS;
        end
      end
      WAIT_VS: begin
        pend_set = bus.req_valid;
        if (vs_edge || cnt == VS_LAST) state_nxt = BLANK;
      end
      BLANK: begin
        pend_set = bus.req_valid;
        if (cnt == BLANK_LAST) state_nxt = SWITCH;
      end
      SWITCH: begin
        pend_set  = bus.req_valid;
        state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        pend_set = bus.req_valid;
        if (lock_sel && stab == STAB_LAST) state_nxt = SETTLE;
        else if (cnt == LOCK_LAST)         state_nxt = FAULT;
      end
      SETTLE: begin
        pend_set = bus.req_valid;
        if (!lock_sel) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == SETTLE_LAST) begin
          pend_set  = 1'b0;
          pend_clr  = 1'b1;
          state_nxt = IDLE;
          if (pend_eff && pend_val_eff != committed) begin
            lat_load  = 1'b1;
            lat_val   = pend_val_eff;
            state_nxt = WAIT_VS;
          end
        end
      end
      FAULT: begin
        if (bus.req_valid) begin
          lat_load  = 1'b1;
          pend_clr  = 1'b1;
          state_nxt = BLANK;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      stab     <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      req_lat  <= '0;
      res_q    <= RESET_RES;
      img_q    <= '0;
      out_q    <= 1'b0;
      blank_q  <= 1'b1;
      tmds_q   <= 1'b1;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)  cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + 1'b1;

      if (state_nxt != state || !lock_sel) stab <= '0;
      else if (stab != '1)                 stab <= stab + 1'b1;

      if (pend_clr) begin
        pend <= 1'b0;
      end else if (pend_set) begin
        pend     <= 1'b1;
        pend_val <= req_now;
      end

      if (lat_load) req_lat <= lat_val;
      if (state == SWITCH) {res_q, img_q, out_q} <= req_lat;

      blank_q <= state_nxt inside {BLANK, SWITCH, WAIT_LOCK, SETTLE, FAULT};
      tmds_q  <= state_nxt inside {SWITCH, WAIT_LOCK, FAULT};
      busy_q  <= state_nxt != IDLE;
      err_q   <= state_nxt == FAULT;
    end
  end

  assign bus.Res_Select = res_q;
  assign bus.Img_Select = img_q;
  assign bus.Out_Select = out_q;
  assign bus.blank      = blank_q;
  assign bus.tmds_rst   = tmds_q;
  assign bus.busy       = busy_q;
  assign bus.lock_err   = err_q;

endmodule
